// File: rtl/core_launcher.sv
// Host-side launcher for the core req/done handshake: loads an input image into data
// memory, pulses core_req, times the run, then streams a result window back out.
module core_launcher #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned LOAD_BASE = 0,
  parameter int unsigned LOAD_LEN  = 64,
  parameter int unsigned DUMP_BASE = 64,
  parameter int unsigned DUMP_LEN  = 64,
  parameter int unsigned REQ_CYC   = 2,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          core_req,
  input  logic          core_done,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          status_ok,
  output logic          status_timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_RUN, S_DUMP, S_DONE
  } state_e;

  state_e        state_q;
  logic [31:0]   idx_q;
  logic [31:0]   req_cnt_q;
  logic [31:0]   run_cnt_q;
  logic [31:0]   run_cnt_d;
  logic          core_req_q;
  logic          res_valid_q;
  logic [DW-1:0] res_data_q;
  logic          status_ok_q;
  logic          status_to_q;
  logic [CW-1:0] cycle_cnt_q;
  logic [CW-1:0] cycle_cnt_d;
  logic          dump_load;
  logic          dump_acc;

  assign run_cnt_d   = run_cnt_q + 32'd1;
  assign cycle_cnt_d = (cycle_cnt_q == '1) ? '1 : cycle_cnt_q + CW'(1);
  // The output register refills whenever it is empty or being drained this cycle.
  assign dump_load   = (!res_valid_q || res_ready) && (idx_q < DUMP_LEN);
  assign dump_acc    = res_valid_q && res_ready;

  assign busy           = (state_q != S_IDLE);
  assign ld_ready       = (state_q == S_LOAD);
  assign mem_own        = (state_q == S_LOAD) || (state_q == S_DUMP);
  assign mem_wr_en      = ld_valid && ld_ready;
  assign mem_wr_data    = ld_data;
  assign core_req       = core_req_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign status_ok      = status_ok_q;
  assign status_timeout = status_to_q;
  assign cycle_count    = cycle_cnt_q;

  always_comb begin
    mem_addr = '0;
    case (state_q)
      S_LOAD:  mem_addr = AW'(LOAD_BASE + idx_q);
      S_DUMP:  mem_addr = AW'(DUMP_BASE + idx_q);
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      req_cnt_q   <= '0;
      run_cnt_q   <= '0;
      core_req_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      status_ok_q <= 1'b0;
      status_to_q <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            status_ok_q <= 1'b0;
            status_to_q <= 1'b0;
            cycle_cnt_q <= '0;
            idx_q       <= '0;
            if (LOAD_LEN == 0) begin
              state_q    <= S_REQ;
              core_req_q <= 1'b1;
              req_cnt_q  <= '0;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            if (idx_q == LOAD_LEN - 1) begin
              idx_q      <= '0;
              state_q    <= S_REQ;
              core_req_q <= 1'b1;
              req_cnt_q  <= '0;
            end else begin
              idx_q <= idx_q + 32'd1;
            end
          end
        end
        S_REQ: begin
          if (req_cnt_q == REQ_CYC - 1) begin
            core_req_q <= 1'b0;
            run_cnt_q  <= '0;
            state_q    <= S_RUN;
          end else begin
            req_cnt_q <= req_cnt_q + 32'd1;
          end
        end
        S_RUN: begin
          run_cnt_q   <= run_cnt_d;
          cycle_cnt_q <= cycle_cnt_d;
          // done is checked first so it wins over a simultaneous timeout
          if (core_done) begin
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            if (DUMP_LEN == 0) begin
              status_ok_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_DUMP;
            end
          end else if (run_cnt_d == TIMEOUT) begin
            status_to_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DUMP: begin
          if (dump_load) begin
            res_data_q  <= mem_rd_data;
            res_valid_q <= 1'b1;
            idx_q       <= idx_q + 32'd1;
          end else if (dump_acc) begin
            res_valid_q <= 1'b0;
            if (idx_q == DUMP_LEN) begin
              status_ok_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_launcher.sv
// Randomized bench for core_launcher: a harness data memory plus a reference image of
// what it must hold, with expectations for every cycle derived from the sequencing rules.
module tb_core_launcher;
  localparam int unsigned LB = 254, LL = 4, DB = 252, DL = 8, RC = 2, TO = 16, CW = 4;
  localparam int CCMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, ld_valid, core_done, res_ready;
  logic [7:0]    ld_data, mem_rd_data, mem_addr, mem_wr_data, res_data;
  logic          busy, ld_ready, mem_own, mem_wr_en, core_req, res_valid;
  logic          status_ok, status_timeout;
  logic [CW-1:0] cycle_count;

  logic        u1_start, u1_done;
  logic        u1_busy, u1_ld_ready, u1_mem_own, u1_mem_wr_en, u1_core_req, u1_res_valid;
  logic        u1_status_ok, u1_status_timeout;
  logic [7:0]  u1_mem_addr, u1_mem_wr_data, u1_res_data;
  logic [15:0] u1_cycle_count;

  logic [7:0] dmem [256];
  logic [7:0] ref_mem [256];
  logic       init_we;
  logic [7:0] init_addr, init_data;

  int checks = 0;
  int failures = 0;

  core_launcher #(.AW(8), .DW(8), .LOAD_BASE(LB), .LOAD_LEN(LL), .DUMP_BASE(DB),
                  .DUMP_LEN(DL), .REQ_CYC(RC), .TIMEOUT(TO), .CW(CW)) u0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .core_req(core_req), .core_done(core_done),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .status_ok(status_ok), .status_timeout(status_timeout), .cycle_count(cycle_count));

  core_launcher #(.AW(8), .DW(8), .LOAD_LEN(0), .DUMP_LEN(0), .REQ_CYC(2)) u1 (
    .clk(clk), .reset(reset), .start(u1_start), .busy(u1_busy),
    .ld_valid(1'b0), .ld_data(8'h00), .ld_ready(u1_ld_ready),
    .mem_own(u1_mem_own), .mem_wr_en(u1_mem_wr_en), .mem_addr(u1_mem_addr),
    .mem_wr_data(u1_mem_wr_data), .mem_rd_data(8'h00),
    .core_req(u1_core_req), .core_done(u1_done),
    .res_valid(u1_res_valid), .res_data(u1_res_data), .res_ready(1'b1),
    .status_ok(u1_status_ok), .status_timeout(u1_status_timeout),
    .cycle_count(u1_cycle_count));

  always @(posedge clk) begin
    if (init_we) dmem[init_addr] <= init_data;
    else if (mem_own && mem_wr_en) dmem[mem_addr] <= mem_wr_data;
  end
  assign mem_rd_data = dmem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);         chk("rst_req", core_req, 0);
    chk("rst_resv", res_valid, 0);    chk("rst_resd", res_data, 0);
    chk("rst_ok", status_ok, 0);      chk("rst_to", status_timeout, 0);
    chk("rst_cc", cycle_count, 0);    chk("rst_own", mem_own, 0);
    chk("rst_ldr", ld_ready, 0);      chk("rst_addr", mem_addr, 0);
  endtask

  // done_at: RUN cycle (1-based) with core_done high, 0 = never; rdy_mode: 0 always,
  // 1 repeating 1,0,0,1, 2 random; abort_at: DUMP cycle to assert reset (0 = none).
  task automatic run_seq(input int done_at, input int rdy_mode, input int abort_at,
                         input int lit_cc);
    int k, guard, r, j, cyc, exp_cc;
    logic ended, done_hit, stalled;
    logic [7:0] ea, prev;
    @(negedge clk); start = 1'b1; #1;
    chk("idle_busy", busy, 0);
    @(negedge clk); start = 1'b0; #1;
    chk("start_ok_clr", status_ok, 0);
    chk("start_to_clr", status_timeout, 0);
    chk("start_cc_clr", cycle_count, 0);
    k = 0; guard = 0;
    while (k < LL && guard < 64) begin
      ld_valid  = (guard == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      ld_data   = 8'($urandom);
      core_done = 1'($urandom);
      #1;
      ea = 8'(LB + k);
      chk("ld_ready", ld_ready, 1);  chk("ld_addr", mem_addr, ea);
      chk("ld_wren", mem_wr_en, ld_valid); chk("ld_wdata", mem_wr_data, ld_data);
      chk("ld_busy", busy, 1);       chk("ld_req", core_req, 0);
      chk("ld_resv", res_valid, 0);
      if (ld_valid) begin ref_mem[ea] = ld_data; k++; end
      guard++;
      @(negedge clk);
    end
    chk("ld_count", k, LL);
    ld_valid = 1'b0;
    for (int c = 0; c < RC; c++) begin
      core_done = 1'($urandom);
      #1;
      chk("req_high", core_req, 1); chk("req_busy", busy, 1);
      chk("req_own", mem_own, 0);   chk("req_addr", mem_addr, 0);
      @(negedge clk);
    end
    r = 1; ended = 1'b0;
    while (!ended) begin
      core_done = (r == done_at);
      start     = (r == 3);
      #1;
      chk("run_req", core_req, 0);  chk("run_busy", busy, 1);
      chk("run_own", mem_own, 0);   chk("run_ldr", ld_ready, 0);
      chk("run_resv", res_valid, 0);
      chk("run_cc", cycle_count, ((r - 1) > CCMAX) ? CCMAX : (r - 1));
      @(negedge clk);
      if (core_done || r == TO) ended = 1'b1;
      else r++;
    end
    core_done = 1'b0; start = 1'b0;
    done_hit = (done_at == r);
    exp_cc = (r > CCMAX) ? CCMAX : r;
    if (done_hit) begin
      j = 0; cyc = 0; stalled = 1'b0; prev = '0;
      while (j < DL && cyc < 200) begin
        case (rdy_mode)
          0:       res_ready = 1'b1;
          1:       res_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          default: res_ready = 1'($urandom);
        endcase
        #1;
        chk("dp_own", mem_own, 1); chk("dp_busy", busy, 1);
        chk("dp_addr", mem_addr, 8'(DB + j + (res_valid ? 1 : 0)));
        if (cyc == 0) chk("dp_first_empty", res_valid, 0);
        if (stalled) begin
          chk("dp_hold_v", res_valid, 1);
          chk("dp_hold_d", res_data, prev);
        end
        if (res_valid && res_ready) begin
          chk("dp_data", res_data, ref_mem[8'(DB + j)]);
          j++;
        end
        stalled = res_valid && !res_ready;
        prev = res_data;
        if (abort_at != 0 && cyc == abort_at) begin
          reset = 1'b0; #1;
          chk_reset_outputs();
          @(negedge clk); reset = 1'b1; res_ready = 1'b0;
          #1;
          chk("abort_idle", busy, 0);
          return;
        end
        @(negedge clk);
        cyc++;
      end
      chk("dp_words", j, DL);
      if (rdy_mode == 0) chk("dp_cycles", cyc, DL + 1);
      #1;
      chk("dn_busy", busy, 1);   chk("dn_ok", status_ok, 1);
      chk("dn_to", status_timeout, 0); chk("dn_resv", res_valid, 0);
      chk("dn_own", mem_own, 0);
    end else begin
      #1;
      chk("to_busy", busy, 1);   chk("to_flag", status_timeout, 1);
      chk("to_ok", status_ok, 0); chk("to_resv", res_valid, 0);
    end
    chk("dn_cc", cycle_count, exp_cc);
    if (lit_cc >= 0) chk("cc_literal", cycle_count, lit_cc);
    @(negedge clk); #1;
    chk("idle_after", busy, 0);
    chk("hold_ok", status_ok, done_hit);
    chk("hold_to", status_timeout, !done_hit);
    chk("hold_cc", cycle_count, exp_cc);
    res_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0; core_done = 1'b0;
    res_ready = 1'b0; u1_start = 1'b0; u1_done = 1'b0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    #1;
    chk_reset_outputs();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      init_we = 1'b1; init_addr = 8'(i); init_data = 8'($urandom);
      ref_mem[i] = init_data;
    end
    @(negedge clk); init_we = 1'b0;
    reset = 1'b1;

    run_seq(10, 0, 0, 10);
    run_seq(5, 1, 0, 5);
    run_seq(0, 0, 0, 15);
    run_seq(1, 0, 0, 1);
    run_seq(16, 0, 0, 15);
    run_seq(3, 2, 4, -1);
    run_seq(2, 0, 0, 2);
    for (int n = 0; n < 6; n++)
      run_seq(int'($urandom_range(1, 20)), 2, 0, -1);

    // Words loaded by the launcher must have landed in the harness memory.
    for (int a = 0; a < LL; a++)
      chk("dmem_img", dmem[8'(LB + a)], ref_mem[8'(LB + a)]);

    // No-load/no-dump instance: IDLE -> REQ -> RUN -> DONE.
    @(negedge clk); u1_start = 1'b1; #1;
    chk("u1_idle", u1_busy, 0);
    @(negedge clk); u1_start = 1'b0; #1;
    chk("u1_req0", u1_core_req, 1); chk("u1_ldr", u1_ld_ready, 0);
    chk("u1_own", u1_mem_own, 0);
    @(negedge clk); #1;
    chk("u1_req1", u1_core_req, 1);
    @(negedge clk); u1_done = 1'b1; #1;
    chk("u1_run_req", u1_core_req, 0); chk("u1_run_busy", u1_busy, 1);
    @(negedge clk); u1_done = 1'b0; #1;
    chk("u1_dn_busy", u1_busy, 1); chk("u1_dn_ok", u1_status_ok, 1);
    chk("u1_dn_cc", u1_cycle_count, 1); chk("u1_dn_resv", u1_res_valid, 0);
    chk("u1_dn_to", u1_status_timeout, 0);
    @(negedge clk); #1;
    chk("u1_idle_after", u1_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
